// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation encodings and burst FSM states.
// Also classifies which operations repeat across a burst.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHL   = 3'd1,
        MODE_SHR   = 3'd2,
        MODE_ROL   = 3'd3,
        MODE_ROR   = 3'd4,
        MODE_LOAD  = 3'd5,
        MODE_ASR   = 3'd6,
        MODE_CLEAR = 3'd7
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Only shift/rotate style operations make sense repeated; HOLD/LOAD/CLEAR are idempotent.
    function automatic logic is_burst_mode(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_op_unit.sv
// Combinational next-value generator for one register step.
// Zero latency; no flow control.
module usr_op_unit
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q_nxt
);

    always_comb begin
        q_nxt = q;
        case (mode)
            MODE_HOLD:  q_nxt = q;
            MODE_SHL:   q_nxt = {q[WIDTH-2:0], ser_in_r};
            MODE_SHR:   q_nxt = {ser_in_l, q[WIDTH-1:1]};
            MODE_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_LOAD:  q_nxt = par_in;
            MODE_ASR:   q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLEAR: q_nxt = '0;
            default:    q_nxt = q;
        endcase
    end

endmodule

// File: rtl/param_universal_shift_register.sv
// Universal shift register with single-step and multi-step burst operation.
// Steps land on the sampling edge; a burst takes one edge per step and ignores control inputs while busy.
module param_universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic [WIDTH-1:0] par_in,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    mode_e            mode_q, mode_q_nxt;
    mode_e            mode_in;
    mode_e            op_mode;
    logic             done_nxt;
    logic             step;
    logic [WIDTH-1:0] q_nxt;

    assign mode_in = mode_e'(mode);

    usr_op_unit #(.WIDTH(WIDTH)) u_op (
        .q        (q),
        .mode     (op_mode),
        .ser_in_l (ser_in_l),
        .ser_in_r (ser_in_r),
        .par_in   (par_in),
        .q_nxt    (q_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= MODE_HOLD;
            done   <= 1'b0;
            q      <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_q_nxt;
            done   <= done_nxt;
            if (step) begin
                q <= q_nxt;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mode_q_nxt = mode_q;
        done_nxt   = 1'b0;
        step       = 1'b0;
        op_mode    = mode_in;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!is_burst_mode(mode_in)) begin
                        step     = 1'b1;
                        done_nxt = 1'b1;
                    end else if (amount == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        step = 1'b1;
                        if (amount == CNT_W'(1)) begin
                            done_nxt = 1'b1;
                        end else begin
                            // The sampling edge already did step 1, so amount-1 remain.
                            state_nxt  = ST_BURST;
                            cnt_nxt    = amount - CNT_W'(1);
                            mode_q_nxt = mode_in;
                        end
                    end
                end else if (en) begin
                    step = 1'b1;
                end
            end
            ST_BURST: begin
                op_mode = mode_q;
                step    = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state == ST_BURST);
    assign ser_out_l = q[WIDTH-1];
    assign ser_out_r = q[0];

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for the universal shift register at WIDTH=8.
module tb_param_universal_shift_register;

    localparam logic [2:0] M_HOLD  = 3'd0;
    localparam logic [2:0] M_SHL   = 3'd1;
    localparam logic [2:0] M_SHR   = 3'd2;
    localparam logic [2:0] M_ROL   = 3'd3;
    localparam logic [2:0] M_LOAD  = 3'd5;
    localparam logic [2:0] M_ASR   = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic       ser_in_l;
    logic       ser_in_r;
    logic [7:0] par_in;
    logic       start;
    logic [3:0] amount;
    logic [7:0] q;
    logic       ser_out_l;
    logic       ser_out_r;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fails  = 0;

    param_universal_shift_register #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .ser_in_l  (ser_in_l),
        .ser_in_r  (ser_in_r),
        .par_in    (par_in),
        .start     (start),
        .amount    (amount),
        .q         (q),
        .ser_out_l (ser_out_l),
        .ser_out_r (ser_out_r),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk8({tag, "_q"}, q, eq);
        chk1({tag, "_busy"}, busy, eb);
        chk1({tag, "_done"}, done, ed);
    endtask

    initial begin
        logic [7:0] exp_q;

        reset = 1'b1; en = 1'b0; mode = M_HOLD; ser_in_l = 1'b0; ser_in_r = 1'b0;
        par_in = 8'h00; start = 1'b0; amount = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        chk1("reset_sol", ser_out_l, 1'b0);
        chk1("reset_sor", ser_out_r, 1'b0);
        reset = 1'b0;

        // single-step LOAD then SHL on the first edges after reset
        en = 1'b1; mode = M_LOAD; par_in = 8'hA5;
        tick();
        chk8("load_a5", q, 8'hA5);
        mode = M_SHL; ser_in_r = 1'b1;
        tick();
        chk8("shl_4b", q, 8'h4B);
        chk1("shl_sol", ser_out_l, 1'b0);
        chk1("shl_sor", ser_out_r, 1'b1);
        en = 1'b0; ser_in_r = 1'b0;
        tick();
        chk8("idle_hold", q, 8'h4B);

        // ROL burst of 3 from 81
        en = 1'b1; mode = M_LOAD; par_in = 8'h81;
        tick();
        en = 1'b0; start = 1'b1; mode = M_ROL; amount = 4'd3;
        tick();
        start = 1'b0; mode = M_HOLD; amount = 4'd0;
        chk_state("rol_e1", 8'h03, 1'b1, 1'b0);
        tick();
        chk_state("rol_e2", 8'h06, 1'b1, 1'b0);
        tick();
        chk_state("rol_e3", 8'h0C, 1'b0, 1'b1);
        tick();
        chk_state("rol_after", 8'h0C, 1'b0, 1'b0);

        // ASR burst of 10 (beyond WIDTH) with control inputs toggling mid-burst
        en = 1'b1; mode = M_LOAD; par_in = 8'h80;
        tick();
        en = 1'b0; start = 1'b1; mode = M_ASR; amount = 4'd10;
        exp_q = 8'h80;
        tick();
        exp_q = {exp_q[7], exp_q[7:1]};
        chk_state("asr_e1", exp_q, 1'b1, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            en = i[0]; start = 1'b1; mode = i[0] ? M_CLEAR : M_LOAD;
            par_in = 8'h00; amount = 4'd1;
            tick();
            exp_q = {exp_q[7], exp_q[7:1]};
            chk_state($sformatf("asr_e%0d", i), exp_q, 1'b1, 1'b0);
        end
        en = 1'b0; start = 1'b0; mode = M_HOLD; amount = 4'd0;
        tick();
        chk_state("asr_e10", 8'hFF, 1'b0, 1'b1);
        tick();
        chk_state("asr_after", 8'hFF, 1'b0, 1'b0);

        // amount=0 on a shift mode: no step, done only
        start = 1'b1; mode = M_SHL; amount = 4'd0;
        tick();
        start = 1'b0; mode = M_HOLD;
        chk_state("amt0", 8'hFF, 1'b0, 1'b1);
        tick();
        chk_state("amt0_after", 8'hFF, 1'b0, 1'b0);

        // CLEAR then amount=1 SHR with ser_in_l=1
        en = 1'b1; mode = M_CLEAR;
        tick();
        en = 1'b0; chk8("clear", q, 8'h00);
        start = 1'b1; mode = M_SHR; amount = 4'd1; ser_in_l = 1'b1;
        tick();
        start = 1'b0; mode = M_HOLD; ser_in_l = 1'b0;
        chk_state("amt1_shr", 8'h80, 1'b0, 1'b1);
        tick();
        chk_state("amt1_after", 8'h80, 1'b0, 1'b0);

        // LOAD via start ignores amount and completes at once
        start = 1'b1; mode = M_LOAD; amount = 4'd5; par_in = 8'h3C;
        tick();
        start = 1'b0; mode = M_HOLD;
        chk_state("start_load", 8'h3C, 1'b0, 1'b1);
        tick();

        // reset mid-burst: SHL amount 6, abort after 2 steps
        start = 1'b1; mode = M_SHL; amount = 4'd6; ser_in_r = 1'b0;
        tick();
        start = 1'b0; mode = M_HOLD;
        chk_state("abort_e1", 8'h78, 1'b1, 1'b0);
        tick();
        chk_state("abort_e2", 8'hF0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk_state("abort_async", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_state($sformatf("abort_post%0d", i), 8'h00, 1'b0, 1'b0);
        end

        // back-to-back bursts: SHL x2 then ROL x3 started on the done cycle
        en = 1'b1; mode = M_LOAD; par_in = 8'h01;
        tick();
        en = 1'b0; start = 1'b1; mode = M_SHL; amount = 4'd2;
        tick();
        start = 1'b0; mode = M_HOLD;
        chk_state("b2b_a1", 8'h02, 1'b1, 1'b0);
        tick();
        chk_state("b2b_a2", 8'h04, 1'b0, 1'b1);
        start = 1'b1; mode = M_ROL; amount = 4'd3;
        tick();
        start = 1'b0; mode = M_HOLD;
        chk_state("b2b_b1", 8'h08, 1'b1, 1'b0);
        tick();
        chk_state("b2b_b2", 8'h10, 1'b1, 1'b0);
        tick();
        chk_state("b2b_b3", 8'h20, 1'b0, 1'b1);
        tick();
        chk_state("b2b_after", 8'h20, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/param_universal_shift_register.md
PARAM_UNIVERSAL_SHIFT_REGISTER -- requirements
Module: param_universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2 to 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1): width of the burst shift amount.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  single-step enable; executes mode for one cycle when idle.
REQ-006 mode  input  3  operation: 0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD, 6 ASR, 7 CLEAR.
REQ-007 ser_in_l  input  1  serial input entering the MSB on SHR.
REQ-008 ser_in_r  input  1  serial input entering the LSB on SHL.
REQ-009 par_in  input  WIDTH  parallel load data.
REQ-010 start  input  1  burst request; sampled only in IDLE.
REQ-011 amount  input  CNT_W  burst step count.
REQ-012 q  output  WIDTH  register contents.
REQ-013 ser_out_l  output  1  combinational q[WIDTH-1].
REQ-014 ser_out_r  output  1  combinational q[0].
REQ-015 busy  output  1  high while a burst is in progress.
REQ-016 done  output  1  one-cycle pulse at burst completion.

Function
REQ-017 Operations per step:
- SHL: q <= {q[WIDTH-2:0], ser_in_r}.
- SHR: q <= {ser_in_l, q[WIDTH-1:1]}.
- ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- ROR: q <= {q[0], q[WIDTH-1:1]}.
- LOAD: q <= par_in.
- ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
- CLEAR: q <= 0.
- HOLD: q unchanged.
REQ-018 FSM states: IDLE and BURST; reset state is IDLE.
REQ-019 In IDLE with start=0 and en=1: one step of mode on that edge, zero latency.
REQ-020 In IDLE with start=0 and en=0: q holds.
REQ-021 In IDLE with start=1: start overrides en, and the sampling edge latches mode and performs the first step.
REQ-022 Burst with mode in {1,2,3,4,6} and amount=N>=2: one step per edge for N edges total using the latched mode; busy=1 after edges 1..N-1; done=1 and busy=0 after edge N.
REQ-023 Burst with amount=1: single step; done=1 and busy=0 after the sampling edge; FSM stays IDLE.
REQ-024 Burst with amount=0: no step, q unchanged; done=1 for one cycle after the sampling edge.
REQ-025 Burst with mode in {0,5,7}: executes once regardless of amount; done=1 for one cycle after the sampling edge.
REQ-026 amount greater than WIDTH is legal; shifts continue filling, and rotates wrap modulo WIDTH naturally.
REQ-027 During BURST, en, mode, start and amount are ignored; ser_in_l/ser_in_r are sampled live on every step.
REQ-028 done is registered, high exactly one cycle, and never coincident with busy=1.
REQ-029 A new start is accepted on the cycle done is high (FSM is IDLE), giving back-to-back bursts.
REQ-030 Remaining-step counter is CNT_W bits and decrements once per BURST step; it never underflows.

Reset
REQ-031 reset=1 asynchronously forces q=0, busy=0, done=0, FSM=IDLE and counter=0, independent of clk.
REQ-032 Reset asserted mid-burst aborts the burst; no done pulse is produced for it.
REQ-033 First operation is accepted on the first rising edge after reset deasserts.

Structure
REQ-034 Shared package usr_pkg holds the mode enum (3-bit, encodings per REQ-006) and the FSM state enum.
REQ-035 Sub-module usr_op_unit is purely combinational: (q, mode, ser_in_l, ser_in_r, par_in) -> next q, parametrised by WIDTH.
REQ-036 The top level holds the q register, the FSM, the counter, the latched mode and the done register.

Verification (WIDTH=8)
REQ-037 LOAD 8'hA5 via en, then en+SHL with ser_in_r=1 -> q=8'h4B; ser_out_l=0, ser_out_r=1.
REQ-038 q=8'h81, start, ROL, amount=3 -> q=8'h0C after edge 3; busy high after edges 1-2 only; done pulse after edge 3.
REQ-039 q=8'h80, start, ASR, amount=10 -> q=8'hFF; done pulse after edge 10; en/mode toggling during burst has no effect.
REQ-040 start with amount=0 -> q unchanged, done one cycle, busy never high; start with amount=1, SHR, ser_in_l=1 from q=0 -> q=8'h80, done, busy never high.
REQ-041 Reset asserted asynchronously mid-burst (amount=6, after 2 steps) -> q=0, busy=0 immediately; no done pulse.
REQ-042 Back-to-back: second start on the done cycle -> accepted; total steps = sum of both amounts; two distinct done pulses.
